// File: rtl/bcd_conversion_scheduler_if.sv
// Bundle of requester, converter and result signals for the BCD conversion
// scheduler. The scheduler itself uses the slave view; the environment
// (requesters plus converter) uses the master view.
interface bcd_conversion_scheduler_if;
  // requester side
  logic [2:0] req;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] gnt;

  // shared binary-to-BCD converter side
  logic       conv_start;
  logic [7:0] conv_data;
  logic       conv_done;
  logic [3:0] conv_d1;
  logic [3:0] conv_d10;
  logic [3:0] conv_d100;

  // result / status side
  logic       res_valid;
  logic [1:0] res_id;
  logic [3:0] res_d1;
  logic [3:0] res_d10;
  logic [3:0] res_d100;
  logic       busy;
  logic       timeout_err;

  modport slave (
    input  req, data0, data1, data2,
    input  conv_done, conv_d1, conv_d10, conv_d100,
    output gnt, conv_start, conv_data,
    output res_valid, res_id, res_d1, res_d10, res_d100,
    output busy, timeout_err
  );

  modport master (
    output req, data0, data1, data2,
    output conv_done, conv_d1, conv_d10, conv_d100,
    input  gnt, conv_start, conv_data,
    input  res_valid, res_id, res_d1, res_d10, res_d100,
    input  busy, timeout_err
  );
endinterface

// File: rtl/bcd_conversion_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD converter between three
// requesters. One conversion is in flight at a time; a conversion that the
// converter never answers is abandoned after TIMEOUT_CYCLES wait cycles.
module bcd_conversion_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  bcd_conversion_scheduler_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // state and datapath registers
  state_t     state_reg,       state_next;
  logic [7:0] wait_cnt_reg,    wait_cnt_next;
  logic [1:0] last_reg,        last_next;
  logic [2:0] gnt_reg,         gnt_next;
  logic       conv_start_reg,  conv_start_next;
  logic [7:0] conv_data_reg,   conv_data_next;
  logic       res_valid_reg,   res_valid_next;
  logic       timeout_err_reg, timeout_err_next;
  logic [1:0] res_id_reg,      res_id_next;
  logic [3:0] res_d1_reg,      res_d1_next;
  logic [3:0] res_d10_reg,     res_d10_next;
  logic [3:0] res_d100_reg,    res_d100_next;

  // round-robin candidates: slot 0 is last+1, slot 1 is last+2, slot 2 is last
  logic [1:0] cand_idx [3];
  logic [2:0] cand_req;
  logic       win_valid;
  logic [1:0] win_idx;
  logic [7:0] win_data;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    localparam logic [2:0] OFFSET = 3'(gi + 1);
    logic [2:0] cand_sum;
    assign cand_sum      = {1'b0, last_reg} + OFFSET;
    // sum never exceeds 5, so a single conditional subtract is a full mod 3
    assign cand_idx[gi]  = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
    assign cand_req[gi]  = bus.req[cand_idx[gi]];
  end

  // pick the first asserted requester in round-robin order
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    if (cand_req[0]) begin
      win_valid = 1'b1;
      win_idx   = cand_idx[0];
    end else if (cand_req[1]) begin
      win_valid = 1'b1;
      win_idx   = cand_idx[1];
    end else if (cand_req[2]) begin
      win_valid = 1'b1;
      win_idx   = cand_idx[2];
    end
  end

  // operand mux for the winning requester
  always_comb begin
    case (win_idx)
      2'd0:    win_data = bus.data0;
      2'd1:    win_data = bus.data1;
      2'd2:    win_data = bus.data2;
      default: win_data = 8'd0;
    endcase
  end

  // next-state and output decode; pulses default low, latched values hold
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    last_next        = last_reg;
    gnt_next         = 3'b000;
    conv_start_next  = 1'b0;
    conv_data_next   = conv_data_reg;
    res_valid_next   = 1'b0;
    timeout_err_next = 1'b0;
    res_id_next      = res_id_reg;
    res_d1_next      = res_d1_reg;
    res_d10_next     = res_d10_reg;
    res_d100_next    = res_d100_reg;

    case (state_reg)
      ST_IDLE: begin
        // conv_done is deliberately not looked at here
        if (win_valid) begin
          state_next      = ST_WAIT;
          wait_cnt_next   = 8'd0;
          last_next       = win_idx;
          gnt_next        = 3'b001 << win_idx;
          conv_start_next = 1'b1;
          conv_data_next  = win_data;
        end
      end

      ST_WAIT: begin
        wait_cnt_next = wait_cnt_reg + 8'd1;
        // a done pulse coinciding with the start pulse cannot belong to this
        // conversion; a done on the timeout edge still counts as a result
        if (bus.conv_done && !conv_start_reg) begin
          state_next     = ST_IDLE;
          wait_cnt_next  = 8'd0;
          res_valid_next = 1'b1;
          res_id_next    = last_reg;
          res_d1_next    = bus.conv_d1;
          res_d10_next   = bus.conv_d10;
          res_d100_next  = bus.conv_d100;
        end else if (wait_cnt_reg + 8'd1 == TIMEOUT_LIMIT) begin
          state_next       = ST_IDLE;
          wait_cnt_next    = 8'd0;
          timeout_err_next = 1'b1;
          res_id_next      = last_reg;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // register update; reset leaves requester 0 with first priority
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      wait_cnt_reg    <= 8'd0;
      last_reg        <= 2'd2;
      gnt_reg         <= 3'b000;
      conv_start_reg  <= 1'b0;
      conv_data_reg   <= 8'd0;
      res_valid_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      res_id_reg      <= 2'd0;
      res_d1_reg      <= 4'd0;
      res_d10_reg     <= 4'd0;
      res_d100_reg    <= 4'd0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      last_reg        <= last_next;
      gnt_reg         <= gnt_next;
      conv_start_reg  <= conv_start_next;
      conv_data_reg   <= conv_data_next;
      res_valid_reg   <= res_valid_next;
      timeout_err_reg <= timeout_err_next;
      res_id_reg      <= res_id_next;
      res_d1_reg      <= res_d1_next;
      res_d10_reg     <= res_d10_next;
      res_d100_reg    <= res_d100_next;
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.conv_start  = conv_start_reg;
  assign bus.conv_data   = conv_data_reg;
  assign bus.res_valid   = res_valid_reg;
  assign bus.timeout_err = timeout_err_reg;
  assign bus.res_id      = res_id_reg;
  assign bus.res_d1      = res_d1_reg;
  assign bus.res_d10     = res_d10_reg;
  assign bus.res_d100    = res_d100_reg;
  assign bus.busy        = (state_reg == ST_WAIT);

endmodule

// File: doc/bcd_conversion_scheduler.md
BCD_CONVERSION_SCHEDULER -- requirements
Module: bcd_conversion_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the maximum WAIT cycles before a conversion is abandoned (legal range 2..255).
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
REQ-004 req  input  3  per-requester conversion request, level; bit i belongs to requester i.
REQ-005 data0, data1, data2  input  8 each  binary value of requester 0/1/2; sampled only on that requester's grant edge.
REQ-006 gnt  output  3  one-hot, one-cycle pulse: the requester's data was captured; the requester may drop req afterwards.
REQ-007 conv_start  output  1  one-cycle start pulse to the shared binary-to-BCD converter.
REQ-008 conv_data  output  8  operand to the converter; valid while conv_start=1 and held until the next grant.
REQ-009 conv_done  input  1  one-cycle pulse from the converter: conv_d1/conv_d10/conv_d100 valid this cycle.
REQ-010 conv_d1, conv_d10, conv_d100  input  4 each  converter result digits.
REQ-011 res_valid  output  1  one-cycle pulse: res_* hold a new result.
REQ-012 res_id  output  2  index (0..2) of the requester owning the result.
REQ-013 res_d1, res_d10, res_d100  output  4 each  latched BCD digits; hold until the next res_valid.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 timeout_err  output  1  one-cycle pulse: conversion abandoned; res_id identifies the requester.

Function
REQ-016 The FSM SHALL have two states: IDLE and WAIT.
REQ-017 IDLE with req==0: remain in IDLE; all pulse outputs 0.
REQ-018 IDLE with req!=0, edge N: select winner i (round-robin); at N+1 gnt[i]=1, conv_start=1, conv_data=data_i (sampled at edge N), state=WAIT, wait counter=0.
REQ-019 Round-robin: search order is last+1, last+2, last (mod 3), where last is the most recently granted index; last updates on every grant.
REQ-020 The winner is always granted regardless of the order in which req bits rose; only asserted bits are eligible.
REQ-021 WAIT: wait counter increments by 1 each cycle.
REQ-022 conv_done is ignored in the cycle conv_start=1.
REQ-023 On conv_done, edge M: at M+1 res_valid=1, res_id=i, res_d*=conv_d* sampled at edge M, state=IDLE.
REQ-024 If the counter reaches TIMEOUT_CYCLES without conv_done: timeout_err=1 and res_id=i for one cycle, res_valid stays 0, res_d* keep old values, state=IDLE.
REQ-025 If conv_done and timeout coincide on the same edge, conv_done wins; no timeout_err.
REQ-026 conv_done received while in IDLE SHALL be ignored.
REQ-027 New req changes during WAIT SHALL NOT affect the in-flight conversion.
REQ-028 Back-to-back conversions: next grant no earlier than the cycle after res_valid/timeout_err; minimum 3 cycles between grants.
REQ-029 gnt, conv_start, res_valid and timeout_err SHALL never exceed one cycle per event and SHALL be mutually exclusive in time, except gnt with conv_start.

Reset
REQ-030 reset=1 at an edge: state=IDLE, last=2 (requester 0 has first priority), counter=0.
REQ-031 Reset values: gnt, conv_start, res_valid, timeout_err, busy = 0; conv_data, res_id, res_d1, res_d10, res_d100 = 0.
REQ-032 Reset mid-WAIT abandons the conversion; no res_valid or timeout_err; a late conv_done after reset is ignored.

Verification
REQ-033 Single request: req=001, data0=8'd237 -> gnt=001 with conv_start and conv_data=237; model converter done after 20 cycles with 7/3/2 -> res_valid, res_id=0, res_d100=2, res_d10=3, res_d1=7.
REQ-034 Fairness: req=111 held, converter replies in 5 cycles -> grants in order 0,1,2,0,1,2; each grant spaced at least 3 cycles.
REQ-035 Timeout: TIMEOUT_CYCLES=10, req=010, converter silent -> timeout_err with res_id=1 exactly 10 cycles after conv_start; res_valid never asserted; res_d* unchanged.
REQ-036 Done/timeout collision: conv_done on the timeout cycle -> res_valid=1, timeout_err=0.
REQ-037 Reset mid-WAIT: reset at cycle 3 of WAIT, then conv_done -> no res_valid; busy=0; next req=100 granted normally.
REQ-038 Data stability: data2 changes after gnt[2] -> conv_data keeps the captured value; zero input 8'd0 -> res digits 0/0/0 with res_valid.
